// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I execute-stage ALU.
// Operation codes, data/shift widths and a bit-reverse helper used by the shifter.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_SEQ   = 4'd11,
    ALU_SGE   = 4'd12,
    ALU_SGEU  = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_mode_e;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by reversing the word on the way in and out.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               right,
  input  logic               arith,
  output logic [XLEN-1:0]    y
);

  logic            fill;
  logic [XLEN-1:0] stage;

  always_comb begin
    fill  = arith & right & a[XLEN-1];
    stage = right ? a : bit_rev(a);
    for (int s = 0; s < SHAMT_W; s++) begin
      if (shamt[s]) begin
        stage = (stage >> (1 << s)) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> (1 << s)));
      end
    end
    y = right ? stage : bit_rev(stage);
  end

endmodule

// File: rtl/rv32i_alu.sv
// Registered 32-bit RV32I ALU: one shared 33-bit adder, barrel shifter, result mux, output register.
// Define ALU_FLAGS_EN to add the registered {zero, neg, carry, ovf} flags port.
module rv32i_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      mode,
  output logic [XLEN-1:0] out
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]      flags
`endif
);

  alu_mode_e       op;
  logic            sub_op;
  logic [XLEN-1:0] b_op;
  logic [XLEN:0]   sum;
  logic            carry;
  logic            ovf;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] shift_y;
  logic [XLEN-1:0] result;

  assign op = alu_mode_e'(mode);

  // SUB and every compare go through the same a + ~b + 1 path.
  always_comb begin
    sub_op = 1'b0;
    case (op)
      ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SEQ, ALU_SGE, ALU_SGEU: sub_op = 1'b1;
      default: sub_op = 1'b0;
    endcase
  end

  assign b_op  = sub_op ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub_op};
  assign carry = sum[XLEN];
  assign ovf   = (a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign lt_s  = sum[XLEN-1] ^ ovf;
  assign lt_u  = ~carry;

  alu_shifter u_shifter (
    .a     (a),
    .shamt (b[SHAMT_W-1:0]),
    .right ((op == ALU_SRL) || (op == ALU_SRA)),
    .arith (op == ALU_SRA),
    .y     (shift_y)
  );

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD, ALU_SUB:          result = sum[XLEN-1:0];
      ALU_AND:                   result = a & b;
      ALU_OR:                    result = a | b;
      ALU_XOR:                   result = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: result = shift_y;
      ALU_SLT:                   result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:                  result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_PASSB:                 result = b;
      ALU_SEQ:                   result = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_SGE:                   result = {{(XLEN-1){1'b0}}, ~lt_s};
      ALU_SGEU:                  result = {{(XLEN-1){1'b0}}, ~lt_u};
      default:                   result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= result;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_d;

  // Carry is the raw adder carry-out, which for subtract paths is NOT borrow.
  always_comb begin
    flags_d    = '0;
    flags_d[3] = (result == '0);
    flags_d[2] = result[XLEN-1];
    flags_d[1] = ((op == ALU_ADD) || sub_op) ? carry : 1'b0;
    flags_d[0] = ((op == ALU_ADD) || (op == ALU_SUB)) ? ovf : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else begin
      flags <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed cases, a stepped sweep over all modes and random back-to-back ops.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_rv32i_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  mode;
  logic [31:0] out;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  m;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
  } vec_t;

  rv32i_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .mode  (mode),
    .out   (out)
`ifdef ALU_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_out(input logic [31:0] x, input logic [31:0] y, input int m);
    int unsigned sh;
    sh = y % 32;
    case (m)
      0:  return x + y;
      1:  return x - y;
      2:  return x & y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return x << sh;
      6:  return x >> sh;
      7:  return $signed(x) >>> sh;
      8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      9:  return (x < y) ? 32'd1 : 32'd0;
      10: return y;
      11: return (x == y) ? 32'd1 : 32'd0;
      12: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
      13: return (x >= y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] x, input logic [31:0] y, input int m);
    logic [31:0] r;
    longint      s;
    logic        c;
    logic        v;
    r = ref_out(x, y, m);
    c = 1'b0;
    v = 1'b0;
    if (m == 0) begin
      c = ((longint'(x) + longint'(y)) > 64'sd4294967295);
      s = longint'($signed(x)) + longint'($signed(y));
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (m == 1 || m == 8 || m == 9 || m == 11 || m == 12 || m == 13) begin
      c = (x >= y);
      if (m == 1) begin
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    end
    return {(r == 32'd0), r[31], c, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'd5; b = 32'd8; mode = 4'd0;
    #12;
    checks++;
    if (out !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold out=%h expected=%h", out, 32'd0);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (flags !== 4'd0) begin
      failures++;
      $display("FAIL reset_flags flags=%b expected=%b", flags, 4'd0);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 32'd13) begin
      failures++;
      $display("FAIL reset_release out=%0d expected=%0d", out, 13);
    end
    a = 32'h1234_5678; b = 32'h1111_1111; mode = 4'd0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 32'd0) begin
      failures++;
      $display("FAIL reset_async out=%h expected=%h", out, 32'd0);
    end
    a = 32'd7; b = 32'd9; mode = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 32'd16) begin
      failures++;
      $display("FAIL reset_first_capture out=%0d expected=%0d", out, 16);
    end
  endtask

  task automatic test_arith();
    vec_t v[4];
    v[0] = '{4'd0, 32'd32767, 32'd32767, 32'd65534};
    v[1] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    v[2] = '{4'd1, 32'd20, 32'd16, 32'd4};
    v[3] = '{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      a = v[i].x; b = v[i].y; mode = v[i].m;
      step();
      checks++;
      if (out !== v[i].e) begin
        failures++;
        $display("FAIL arith[%0d] out=%h expected=%h", i, out, v[i].e);
      end
`ifdef ALU_FLAGS_EN
      if (i == 1) begin
        checks++;
        if (flags !== 4'b1010) begin
          failures++;
          $display("FAIL arith_wrap_flags flags=%b expected=%b", flags, 4'b1010);
        end
      end
`endif
    end
  endtask

  task automatic test_logic();
    vec_t v[4];
    v[0] = '{4'd2, 32'd20, 32'd16, 32'd16};
    v[1] = '{4'd3, 32'd8, 32'd4, 32'd12};
    v[2] = '{4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0};
    v[3] = '{4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0};
    for (int i = 0; i < 4; i++) begin
      a = v[i].x; b = v[i].y; mode = v[i].m;
      step();
      checks++;
      if (out !== v[i].e) begin
        failures++;
        $display("FAIL logic[%0d] out=%h expected=%h", i, out, v[i].e);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[4];
    v[0] = '{4'd5, 32'd1, 32'd31, 32'h8000_0000};
    v[1] = '{4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000};
    v[2] = '{4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000};
    v[3] = '{4'd5, 32'd1, 32'd33, 32'd2};
    for (int i = 0; i < 4; i++) begin
      a = v[i].x; b = v[i].y; mode = v[i].m;
      step();
      checks++;
      if (out !== v[i].e) begin
        failures++;
        $display("FAIL shift[%0d] out=%h expected=%h", i, out, v[i].e);
      end
    end
  endtask

  task automatic test_compare();
    vec_t v[5];
    v[0] = '{4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1};
    v[1] = '{4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0};
    v[2] = '{4'd11, 32'd7, 32'd7, 32'd1};
    v[3] = '{4'd12, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd1};
    v[4] = '{4'd13, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      a = v[i].x; b = v[i].y; mode = v[i].m;
      step();
      checks++;
      if (out !== v[i].e) begin
        failures++;
        $display("FAIL compare[%0d] out=%h expected=%h", i, out, v[i].e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e;
    int          bad;
    bad = 0;
    for (int m = 0; m < 16; m++) begin
      for (int k = 0; k < 128; k++) begin
        a = (3 * k) & 32'hFF; b = (2 * k) & 32'hFF; mode = 4'(m);
        step();
        e = ref_out(a, b, m);
        checks++;
        if (out !== e) begin
          failures++;
          bad++;
          if (bad <= 10) $display("FAIL sweep mode=%0d a=%h b=%h out=%h expected=%h", m, a, b, out, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] pick[6];
    int          bad;
    int          m;
    bad = 0;
    pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF; pick[4] = 32'h1; pick[5] = 32'h20;
    for (int i = 0; i < 600; i++) begin
      m = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      mode = 4'(m);
      step();
      e = ref_out(a, b, m);
      checks++;
      if (out !== e) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL b2b mode=%0d a=%h b=%h out=%h expected=%h", m, a, b, out, e);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (flags !== ref_flags(a, b, m)) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL b2b_flags mode=%0d a=%h b=%h flags=%b expected=%b", m, a, b, flags, ref_flags(a, b, m));
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    mode     = '0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
